os_generator: RTL

OS_GENERATOR -- requirements
Module: os_generator

---
 rtl/ltssm_pkg.sv | 48 ++++
 rtl/os_formatter.sv | 54 +++++
 rtl/os_generator.sv | 113 +++++++++++
 3 files changed

// File: rtl/ltssm_pkg.sv
// Shared LTSSM substate encoding, ordered-set symbols and TX count thresholds.
// Used by the TS1/TS2 generator and the RX ordered-set checker.
package ltssm_pkg;

    localparam int unsigned SUBSTATE_W = 4;
    localparam int unsigned OS_W       = 128;
    localparam int unsigned TXCOUNT_W  = 11;

    localparam logic [SUBSTATE_W-1:0] DETECT_QUIET           = 4'd0;
    localparam logic [SUBSTATE_W-1:0] DETECT_ACTIVE          = 4'd1;
    localparam logic [SUBSTATE_W-1:0] POLLING_ACTIVE         = 4'd2;
    localparam logic [SUBSTATE_W-1:0] POLLING_CONFIGURATION  = 4'd3;
    localparam logic [SUBSTATE_W-1:0] LINKWIDTH_START        = 4'd4;
    localparam logic [SUBSTATE_W-1:0] LINKWIDTH_ACCEPT       = 4'd5;
    localparam logic [SUBSTATE_W-1:0] LANENUM_WAIT           = 4'd6;
    localparam logic [SUBSTATE_W-1:0] LANENUM_ACCEPT         = 4'd7;
    localparam logic [SUBSTATE_W-1:0] CONFIGURATION_COMPLETE = 4'd8;
    localparam logic [SUBSTATE_W-1:0] CONFIGURATION_IDLE     = 4'd9;

    localparam logic [7:0] SYM_COM  = 8'hBC;
    localparam logic [7:0] SYM_PAD  = 8'hF7;
    localparam logic [7:0] SYM_TS1  = 8'h4A;
    localparam logic [7:0] SYM_TS2  = 8'h45;
    localparam logic [7:0] SYM_NFTS = 8'h00;

    localparam int unsigned THRESH_POLLING = 1024;
    localparam int unsigned THRESH_DEFAULT = 16;

    localparam logic [TXCOUNT_W-1:0] TXCOUNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } gen_state_e;

    typedef struct packed {
        logic [7:0] link;
        logic [7:0] lane;
        logic [7:0] rateid;
        logic       upcfg;
    } os_fields_t;

    function automatic logic [TXCOUNT_W-1:0] count_threshold(input logic [SUBSTATE_W-1:0] sub);
        return (sub == POLLING_ACTIVE) ? TXCOUNT_W'(THRESH_POLLING) : TXCOUNT_W'(THRESH_DEFAULT);
    endfunction

endpackage

// File: rtl/os_formatter.sv
// Combinational TS1/TS2 content selection for the current substate and port role.
module os_formatter
    import ltssm_pkg::*;
#(
    parameter int unsigned DEVICETYPE = 0
) (
    input  logic [SUBSTATE_W-1:0] substate,
    input  os_fields_t            fields,
    output logic [OS_W-1:0]       orderedset_c,
    output logic                  transmit_c
);

    logic       is_ts2;
    logic [7:0] link_f;
    logic [7:0] lane_f;
    logic [7:0] ident;
    logic [7:0] ctrl;

    always_comb begin
        transmit_c = 1'b1;
        is_ts2     = 1'b0;
        link_f     = SYM_PAD;
        lane_f     = SYM_PAD;
        case (substate)
            POLLING_ACTIVE: ;
            POLLING_CONFIGURATION: is_ts2 = 1'b1;
            LINKWIDTH_START: begin
                if (DEVICETYPE == 0) link_f = fields.link;
            end
            LINKWIDTH_ACCEPT: begin
                link_f = fields.link;
                if (DEVICETYPE == 0) lane_f = fields.lane;
            end
            LANENUM_WAIT, LANENUM_ACCEPT: begin
                link_f = fields.link;
                lane_f = fields.lane;
            end
            CONFIGURATION_COMPLETE: begin
                is_ts2 = 1'b1;
                link_f = fields.link;
                lane_f = fields.lane;
            end
            DETECT_QUIET, DETECT_ACTIVE, CONFIGURATION_IDLE: transmit_c = 1'b0;
            default: transmit_c = 1'b0;
        endcase
    end

    assign ident = is_ts2 ? SYM_TS2 : SYM_TS1;
    assign ctrl  = {5'b0, fields.upcfg, 2'b0};

    // Byte 0 in the least significant position.
    assign orderedset_c = {{10{ident}}, ctrl, fields.rateid, SYM_NFTS, lane_f, link_f, SYM_COM};

endmodule

// File: rtl/os_generator.sv
// TS1/TS2 ordered-set transmitter: loads content per substate, streams it
// under ready/valid and counts accepted sets against the substate threshold.
module os_generator
    import ltssm_pkg::*;
#(
    parameter int unsigned DEVICETYPE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SUBSTATE_W-1:0] substate,
    input  logic [7:0]            linkNumber,
    input  logic [7:0]            laneNumber,
    input  logic [7:0]            rateid,
    input  logic                  upconfigure_capability,
    input  logic                  ready,
    output logic [OS_W-1:0]       orderedset,
    output logic                  valid,
    output logic [TXCOUNT_W-1:0]  txCount,
    output logic                  countDone
);

    gen_state_e            state_q, state_d;
    logic [OS_W-1:0]       set_q, set_d;
    logic                  valid_q, valid_d;
    logic [TXCOUNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic                  done_q, done_d;
    logic [SUBSTATE_W-1:0] sub_q, sub_d;

    os_fields_t      fields;
    logic [OS_W-1:0] fmt_set;
    logic            transmit_c;

    assign fields = '{link: linkNumber, lane: laneNumber, rateid: rateid, upcfg: upconfigure_capability};

    os_formatter #(.DEVICETYPE(DEVICETYPE)) u_fmt (
        .substate     (substate),
        .fields       (fields),
        .orderedset_c (fmt_set),
        .transmit_c   (transmit_c)
    );

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        sub_d   = sub_q;
        cnt_inc = (cnt_q == TXCOUNT_MAX) ? cnt_q : cnt_q + TXCOUNT_W'(1);
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                done_d  = 1'b0;
                if (transmit_c) state_d = S_LOAD;
            end
            S_LOAD: begin
                done_d = 1'b0;
                cnt_d  = '0;
                if (transmit_c) begin
                    set_d   = fmt_set;
                    sub_d   = substate;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end else begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                // The pending set is only released by acceptance; a substate
                // change is acted upon after that.
                if (valid_q && ready) begin
                    cnt_d  = cnt_inc;
                    done_d = (cnt_inc >= count_threshold(sub_q));
                    if (substate != sub_q) begin
                        valid_d = 1'b0;
                        done_d  = 1'b0;
                        state_d = transmit_c ? S_LOAD : S_IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            set_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sub_q   <= DETECT_QUIET;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sub_q   <= sub_d;
        end
    end

    assign orderedset = set_q;
    assign valid      = valid_q;
    assign txCount    = cnt_q;
    assign countDone  = done_q;

endmodule
